// File: rtl/example_acc_quant.sv
// example_acc_quant: accumulates N_TERMS signed products plus a bias per
// group, then rounds, shifts and clips or wraps the sum to OUT_W bits.
// Ports: ap_clk, ap_rst_n (async low); prod_data/prod_valid/prod_ready in;
//        bias (first beat); out_data/out_valid/out_ready out; sat_flag.
// Option: define EXAMPLE_ACC_QUANT_SAT_EN to clip results and drive sat_flag.
module example_acc_quant #(
    parameter int PROD_W  = 21,
    parameter int N_TERMS = 16,
    parameter int ACC_W   = 26,
    parameter int BIAS_W  = 16,
    parameter int SHIFT   = 8,
    parameter int OUT_W   = 16
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic signed [PROD_W-1:0] prod_data,
    input  logic                     prod_valid,
    output logic                     prod_ready,
    input  logic signed [BIAS_W-1:0] bias,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     sat_flag
);

    localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam int RW    = ACC_W + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);
    localparam logic [RW-1:0]    HALF =
        {{(RW-1){1'b0}}, 1'b1} << (SHIFT - 1);

    typedef enum logic {
        S_ACC,
        S_OUT
    } state_t;

    state_t                  state_q;
    logic [ACC_W-1:0]        acc_q;
    logic [CNT_W-1:0]        cnt_q;
    logic signed [OUT_W-1:0] out_data_q;
    logic                    out_valid_q;
    logic                    prod_ready_q;

    logic [ACC_W-1:0]        prod_ext;
    logic [ACC_W-1:0]        bias_sh;
    logic [ACC_W-1:0]        acc_d;
    logic signed [RW-1:0]    rnd;
    logic signed [RW-1:0]    r;
    logic signed [OUT_W-1:0] q_d;
    logic                    beat;

    assign beat = prod_valid && prod_ready_q;

    // acc_d doubles as the full group sum on the last beat.
    always_comb begin
        prod_ext = {{(ACC_W-PROD_W){prod_data[PROD_W-1]}}, prod_data};
        bias_sh  = {{(ACC_W-BIAS_W){bias[BIAS_W-1]}}, bias};
        bias_sh  = bias_sh << SHIFT;
        acc_d    = ((cnt_q == '0) ? bias_sh : acc_q) + prod_ext;
        // One guard bit so the rounding add cannot wrap.
        rnd      = $signed({acc_d[ACC_W-1], acc_d} + HALF);
        r        = rnd >>> SHIFT;
    end

`ifdef EXAMPLE_ACC_QUANT_SAT_EN
    logic ovf_d;
    logic sat_q;

    // Fits OUT_W only if every bit above the output sign matches it.
    always_comb begin
        ovf_d = !((&r[RW-1:OUT_W-1]) || !(|r[RW-1:OUT_W-1]));
        q_d   = r[OUT_W-1:0];
        if (ovf_d) begin
            if (r[RW-1]) begin
                q_d = {1'b1, {(OUT_W-1){1'b0}}};
            end else begin
                q_d = {1'b0, {(OUT_W-1){1'b1}}};
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            sat_q <= 1'b0;
        end else if (state_q == S_ACC && beat && cnt_q == LAST && ovf_d) begin
            sat_q <= 1'b1;
        end
    end

    assign sat_flag = sat_q;
`else
    logic unused_hi;

    assign q_d       = r[OUT_W-1:0];
    assign unused_hi = ^r[RW-1:OUT_W];
    assign sat_flag  = 1'b0;
`endif

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q      <= S_ACC;
            acc_q        <= '0;
            cnt_q        <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            prod_ready_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_ACC: begin
                    prod_ready_q <= 1'b1;
                    if (beat) begin
                        acc_q <= acc_d;
                        if (cnt_q == LAST) begin
                            cnt_q        <= '0;
                            out_data_q   <= q_d;
                            out_valid_q  <= 1'b1;
                            prod_ready_q <= 1'b0;
                            state_q      <= S_OUT;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid_q  <= 1'b0;
                        prod_ready_q <= 1'b1;
                        state_q      <= S_ACC;
                    end
                end
                default: begin
                    state_q <= S_ACC;
                end
            endcase
        end
    end

    assign prod_ready = prod_ready_q;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_example_acc_quant.sv
// tb_example_acc_quant: table of constant-product groups plus hand-written
// backpressure, gapped-input and asynchronous-reset sequences.
module tb_example_acc_quant;

    localparam int PROD_W = 21;
    localparam int BIAS_W = 16;
    localparam int OUT_W  = 16;
    localparam int NT     = 16;
`ifdef EXAMPLE_ACC_QUANT_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic                     ap_clk = 1'b0;
    logic                     ap_rst_n = 1'b0;
    logic signed [PROD_W-1:0] prod_data = '0;
    logic                     prod_valid = 1'b0;
    logic                     prod_ready;
    logic signed [BIAS_W-1:0] bias = '0;
    logic signed [OUT_W-1:0]  out_data;
    logic                     out_valid;
    logic                     out_ready = 1'b1;
    logic                     sat_flag;

    example_acc_quant dut (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .prod_data  (prod_data),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .bias       (bias),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sat_flag   (sat_flag)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        int prod;
        int bias;
        int exp_sat;
        int exp_wrap;
        bit clip;
    } vec_t;

    typedef struct {
        int data;
        bit clip;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   total = 0;
    int   bad = 0;
    bit   exp_flag = 1'b0;

    task automatic check(input string name, input longint act,
                         input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Scoreboard: pop one expectation per output handshake.
    always @(negedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            exp_flag = 1'b0;
        end else if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out actual=%0d required=none",
                         out_data);
            end else begin
                e = sb.pop_front();
                if (SAT_EN && e.clip) exp_flag = 1'b1;
                check("out_data", out_data, e.data);
                check("sat_flag", sat_flag, exp_flag);
            end
        end
    end

    task automatic send_beat(input int p, input int b);
        bit rdy;
        int n;
        prod_data  = PROD_W'(p);
        bias       = BIAS_W'(b);
        prod_valid = 1'b1;
        n = 0;
        do begin
            @(negedge ap_clk);
            rdy = prod_ready;
            @(posedge ap_clk);
            #1;
            n++;
        end while (!rdy && n < 100);
        prod_valid = 1'b0;
        if (!rdy) begin
            total++;
            bad++;
            $display("FAIL beat_timeout actual=%0d required=1", rdy);
        end
    endtask

    task automatic run_group(input int p, input int b, input bit gap);
        for (int i = 0; i < NT; i++) begin
            if (gap && i > 0) begin
                prod_valid = 1'b0;
                prod_data  = PROD_W'(12345);
                bias       = BIAS_W'(999);
                @(posedge ap_clk);
                #1;
            end
            send_beat(p, (gap && i > 0) ? 777 : b);
        end
        check("latency_valid", out_valid, 1);
        check("ready_low_out", prod_ready, 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge ap_clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout actual=%0d required=0", sb.size());
        end
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{1000, 0, 63, 63, 1'b0};
        vecs[1] = '{-1000, 0, -62, -62, 1'b0};
        vecs[2] = '{0, 5, 5, 5, 1'b0};
        vecs[3] = '{37, -3, -1, -1, 1'b0};
        vecs[4] = '{8, 0, 1, 1, 1'b0};
        vecs[5] = '{-8, 0, 0, 0, 1'b0};
        vecs[6] = '{2047, 32000, 32128, 32128, 1'b0};
        vecs[7] = '{1048575, 0, 32767, 0, 1'b1};
        vecs[8] = '{-1048576, 0, -32768, 0, 1'b1};
        vecs[9] = '{1000, 0, 63, 63, 1'b0};

        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_sat_flag", sat_flag, 0);
        check("rst_prod_ready", prod_ready, 0);
        #20;
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        check("ready_after_rst", prod_ready, 1);

        foreach (vecs[i]) begin
            sb.push_back('{SAT_EN ? vecs[i].exp_sat : vecs[i].exp_wrap,
                           vecs[i].clip});
            run_group(vecs[i].prod, vecs[i].bias, 1'b0);
        end
        drain();

        // Backpressure with a producer that keeps offering beats.
        out_ready = 1'b0;
        sb.push_back('{63, 1'b0});
        run_group(1000, 0, 1'b0);
        prod_valid = 1'b1;
        prod_data  = PROD_W'(1000);
        for (int i = 0; i < 10; i++) begin
            @(negedge ap_clk);
            check("bp_prod_ready", prod_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_out_data", out_data, 63);
        end
        @(posedge ap_clk);
        #1;
        out_ready  = 1'b1;
        prod_valid = 1'b0;
        @(posedge ap_clk);
        #1;
        check("bp_valid_drop", out_valid, 0);
        check("bp_ready_back", prod_ready, 1);
        drain();

        // Gapped input with bias noise on non-first beats.
        sb.push_back('{63, 1'b0});
        run_group(1000, 0, 1'b1);
        drain();

        // Asynchronous reset mid-group.
        for (int i = 0; i < 7; i++) send_beat(5000, 0);
        #2;
        ap_rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ready", prod_ready, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_sat", sat_flag, 0);
        #4;
        ap_rst_n = 1'b1;
        sb.push_back('{63, 1'b0});
        run_group(1000, 0, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

endmodule
